// File: rtl/frame_capture_writer_if.sv
// Sample-in / RAM-write-out bundle of the frame capture writer.
// Latency: none, this file only groups wires.
// Backpressure: none; the sample stream cannot be stalled, and samples with no free bank are dropped.
interface frame_capture_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int DROP_WIDTH = 16
);
    logic                  capture_en;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  sample_valid;
    logic                  frame_ack;
    logic                  ack_bank;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic                  frame_done;
    logic                  frame_bank;
    logic [1:0]            bank_busy;
    logic [DROP_WIDTH-1:0] drop_cnt;
    logic                  overflow;

    // Upstream source / consumer side
    modport master (
        output capture_en, sample_data, sample_valid, frame_ack, ack_bank,
        input  wr_data, wr_addr, wr_en, frame_done, frame_bank, bank_busy, drop_cnt, overflow
    );

    // Writer side
    modport slave (
        input  capture_en, sample_data, sample_valid, frame_ack, ack_bank,
        output wr_data, wr_addr, wr_en, frame_done, frame_bank, bank_busy, drop_cnt, overflow
    );
endinterface

// File: rtl/frame_capture_writer.sv
// Packs a sample stream into FRAME_LEN-sample frames in a ping-pong pair of RAM banks.
// Latency: 1 cycle from accepted sample to registered RAM write / frame_done.
// Backpressure: none; samples arriving while the target bank is still busy are dropped and counted.
module frame_capture_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int FRAME_LEN  = 1024,
    parameter int DROP_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    frame_capture_writer_if.slave bus
);
    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT_BANK} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cur_bank;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_frame_done;
    logic                  r_frame_bank;
    logic [1:0]            r_bank_busy;
    logic [1:0]            w_busy_nxt;
    logic [DROP_WIDTH-1:0] r_drop_cnt;
    logic                  r_overflow;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_frame_end;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: frame boundaries are the only points where capture_en is honoured in FILL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.capture_en)
                    w_state_nxt = r_bank_busy[r_cur_bank] ? S_WAIT_BANK : S_FILL;
            end
            S_FILL: begin
                if (w_frame_end) begin
                    if (!bus.capture_en)               w_state_nxt = S_IDLE;
                    else if (r_bank_busy[~r_cur_bank]) w_state_nxt = S_WAIT_BANK;
                    else                               w_state_nxt = S_FILL;
                end
            end
            S_WAIT_BANK: begin
                if (!r_bank_busy[r_cur_bank])
                    w_state_nxt = bus.capture_en ? S_FILL : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-cycle actions: accept in FILL, drop in WAIT_BANK (including the exit cycle)
    always_comb begin
        w_accept    = (r_state == S_FILL) && bus.sample_valid;
        w_drop      = (r_state == S_WAIT_BANK) && bus.sample_valid;
        w_frame_end = w_accept && (r_idx == IDX_LAST);
    end

    // Write port, frame index and bank pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_idx        <= '0;
            r_cur_bank   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_bank <= 1'b0;
        end else begin
            r_wr_en      <= w_accept;
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_wr_addr <= {r_cur_bank, r_idx};
                r_wr_data <= bus.sample_data;
                r_idx     <= w_frame_end ? '0 : r_idx + 1'b1;
            end
            if (w_frame_end) begin
                r_frame_bank <= r_cur_bank;
                r_cur_bank   <= ~r_cur_bank;
            end
        end
    end

    // Bank ownership: ack releases, frame completion claims; the claim wins on a collision
    always_comb begin
        w_busy_nxt = r_bank_busy;
        if (bus.frame_ack) w_busy_nxt[bus.ack_bank] = 1'b0;
        if (w_frame_end)   w_busy_nxt[r_cur_bank]   = 1'b1;
    end

    // Bank busy register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_bank_busy <= '0;
        else       r_bank_busy <= w_busy_nxt;
    end

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_bank = r_frame_bank;
    assign bus.bank_busy  = r_bank_busy;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed vector bench for frame_capture_writer.
// Inputs driven on the falling edge, outputs checked on the next falling edge.
// Each vector's expectations are hand-derived per scenario.
module tb_frame_capture_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_capture_writer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .DROP_WIDTH(16)) bus ();

    frame_capture_writer #(
        .DATA_WIDTH(16), .ADDR_WIDTH(11), .FRAME_LEN(1024), .DROP_WIDTH(16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        cap;
        logic        vld;
        logic [15:0] dat;
        logic        ack;
        logic        abk;
        logic        en;
        logic [10:0] addr;
        logic [15:0] wdat;
        logic        done;
        logic        fbank;
        logic [1:0]  busy;
        logic [15:0] drop;
        logic        ovf;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic        e_fb;
    logic [1:0]  e_busy;
    logic [15:0] e_drop;
    logic        e_ovf;

    function automatic vec_t mk(input logic r, c, vl, input logic [15:0] d, input logic a, ab,
                                input logic en, input logic [10:0] ad, input logic [15:0] wd,
                                input logic dn);
        vec_t v;
        v.rst = r;  v.cap = c; v.vld = vl; v.dat = d; v.ack = a; v.abk = ab;
        v.en = en;  v.addr = ad; v.wdat = wd; v.done = dn;
        v.fbank = e_fb; v.busy = e_busy; v.drop = e_drop; v.ovf = e_ovf;
        return v;
    endfunction

    task automatic add(input logic r, c, vl, input logic [15:0] d, input logic a, ab,
                       input logic en, input logic [10:0] ad, input logic [15:0] wd, input logic dn);
        vecs.push_back(mk(r, c, vl, d, a, ab, en, ad, wd, dn));
    endtask

    task automatic apply(input vec_t v, input string nm);
        logic ok;
        rst              = v.rst;
        bus.capture_en   = v.cap;
        bus.sample_valid = v.vld;
        bus.sample_data  = v.dat;
        bus.frame_ack    = v.ack;
        bus.ack_bank     = v.abk;
        @(posedge clk);
        @(negedge clk);
        checks++;
        ok = (bus.wr_en === v.en) && (bus.frame_done === v.done) && (bus.frame_bank === v.fbank) &&
             (bus.bank_busy === v.busy) && (bus.drop_cnt === v.drop) && (bus.overflow === v.ovf);
        if (v.en || v.rst)
            ok = ok && (bus.wr_addr === v.addr) && (bus.wr_data === v.wdat);
        if (!ok) begin
            errors++;
            $display("FAIL %s: got en=%0b addr=%0d data=%h done=%0b fbank=%0b busy=%b drop=%0d ovf=%0b | want en=%0b addr=%0d data=%h done=%0b fbank=%0b busy=%b drop=%0d ovf=%0b",
                     nm, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_bank,
                     bus.bank_busy, bus.drop_cnt, bus.overflow,
                     v.en, v.addr, v.wdat, v.done, v.fbank, v.busy, v.drop, v.ovf);
        end
    endtask

    task automatic step(input logic r, c, vl, input logic [15:0] d, input logic a, ab,
                        input logic en, input logic [10:0] ad, input logic [15:0] wd,
                        input logic dn, input string nm);
        apply(mk(r, c, vl, d, a, ab, en, ad, wd, dn), nm);
    endtask

    initial begin
        rst = 1'b1;
        bus.capture_en = 1'b0; bus.sample_valid = 1'b0; bus.sample_data = '0;
        bus.frame_ack = 1'b0;  bus.ack_bank = 1'b0;
        e_fb = 1'b0; e_busy = 2'b00; e_drop = '0; e_ovf = 1'b0;

        // Frame 1: reset, then bank 0 filled with data = n
        add(1, 0, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0);
        add(0, 1, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0);
        for (int n = 0; n < 1024; n++) begin
            if (n == 1023) e_busy = 2'b01;
            add(0, 1, 1, 16'(n), 0, 0, 1, 11'(n), 16'(n), n == 1023);
        end
        // Frame 2: bank 1, then five samples dropped with no free bank
        for (int n = 0; n < 1024; n++) begin
            if (n == 1023) begin e_fb = 1'b1; e_busy = 2'b11; end
            add(0, 1, 1, 16'h8000 | 16'(n), 0, 0, 1, 11'(1024 + n), 16'h8000 | 16'(n), n == 1023);
        end
        e_ovf = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            e_drop = 16'(k);
            add(0, 1, 1, 16'hDEAD, 0, 0, 0, 11'd0, 16'h0, 0);
        end
        // Release bank 0; the exit-cycle sample is still dropped
        e_busy = 2'b10;
        add(0, 1, 0, 16'h0, 1, 0, 0, 11'd0, 16'h0, 0);
        e_drop = 16'd6;
        add(0, 1, 1, 16'hBEEF, 0, 0, 0, 11'd0, 16'h0, 0);
        // Frame 3 in bank 0 with capture_en dropped after sample 500
        for (int n = 0; n < 1024; n++) begin
            if (n == 1023) begin e_fb = 1'b0; e_busy = 2'b11; end
            add(0, n <= 500, 1, 16'h4000 + 16'(n), 0, 0, 1, 11'(n), 16'h4000 + 16'(n), n == 1023);
        end
        for (int k = 0; k < 4; k++)
            add(0, 0, 1, 16'h1111, 0, 0, 0, 11'd0, 16'h0, 0);
        // Free both banks; a repeated ack on an idle bank changes nothing
        e_busy = 2'b01;
        add(0, 0, 0, 16'h0, 1, 1, 0, 11'd0, 16'h0, 0);
        add(0, 0, 0, 16'h0, 1, 1, 0, 11'd0, 16'h0, 0);
        e_busy = 2'b00;
        add(0, 0, 0, 16'h0, 1, 0, 0, 11'd0, 16'h0, 0);
        // Partial frame in bank 1, reset after sample 300, restart at bank 0
        add(0, 1, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0);
        for (int n = 0; n <= 300; n++)
            add(0, 1, 1, 16'h2000 + 16'(n), 0, 0, 1, 11'(1024 + n), 16'h2000 + 16'(n), 0);
        e_drop = '0; e_ovf = 1'b0; e_fb = 1'b0; e_busy = 2'b00;
        add(1, 1, 1, 16'h7777, 0, 0, 0, 11'd0, 16'h0, 0);
        add(0, 1, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0);
        for (int n = 0; n < 4; n++)
            add(0, 1, 1, 16'h3000 + 16'(n), 0, 0, 1, 11'(n), 16'h3000 + 16'(n), 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Sparse stream, one sample in three, with ack and frame completion colliding on bank 0
        e_fb = 1'b0; e_busy = 2'b00; e_drop = '0; e_ovf = 1'b0;
        step(1, 0, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0, "t6_rst");
        step(0, 1, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0, "t6_start");
        for (int n = 0; n < 1024; n++) begin
            if (n == 1023) e_busy = 2'b01;
            step(0, 1, 1, 16'h5000 + 16'(n), (n == 10) || (n == 1023), n == 10,
                 1, 11'(n), 16'h5000 + 16'(n), n == 1023, $sformatf("t6_s%0d", n));
            step(0, 1, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0, $sformatf("t6_g%0da", n));
            step(0, 1, 0, 16'h0, 0, 0, 0, 11'd0, 16'h0, 0, $sformatf("t6_g%0db", n));
        end
        step(0, 1, 1, 16'hC0DE, 0, 0, 1, 11'd1024, 16'hC0DE, 0, "t6_bank1");
        e_busy = 2'b00;
        step(0, 1, 0, 16'h0, 1, 0, 0, 11'd0, 16'h0, 0, "t6_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
